forward_scoreboard: RTL

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

---
 rtl/forward_scoreboard.sv | 112 +++++++++++
 1 files changed

// File: rtl/forward_scoreboard.sv
// forward_scoreboard: tracks destination registers of in-flight instructions,
// forwards the youngest ready producer to each decode read port and raises a
// load-use stall when the youngest producer has no data yet.
// Optional feature: define FWD_STATS_EN to build the saturating stall/forward
// statistics counters; otherwise the stat ports are tied to zero.
module forward_scoreboard #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int STAGES = 3,
  parameter int NPORT  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NPORT-1:0]          id_rd_en,
  input  logic [NPORT*ADDR_W-1:0]   id_rd_addr,
  input  logic                      id_wb_en,
  input  logic [ADDR_W-1:0]         id_wb_addr,
  input  logic                      flush,
  input  logic [STAGES*DATA_W-1:0]  stg_data,
  input  logic [STAGES-1:0]         stg_rdy,
  output logic [NPORT-1:0]          fwd_en,
  output logic [NPORT*DATA_W-1:0]   fwd_data,
  output logic                      stall,
  output logic [15:0]               stat_stall_cnt,
  output logic [15:0]               stat_fwd_cnt
);

  // Per-stage scoreboard entries; index 0 is the youngest (EX).
  logic [STAGES-1:0] valid_r;
  logic [ADDR_W-1:0] addr_r [STAGES];

  logic [NPORT-1:0]  hit_s;
  logic [NPORT-1:0]  port_stall_s;

  // Per port, pick the youngest matching stage; forward it if ready, else flag a stall.
  always_comb begin
    fwd_en       = '0;
    fwd_data     = '0;
    port_stall_s = '0;
    hit_s        = '0;
    for (int p = 0; p < NPORT; p++) begin
      for (int s = 0; s < STAGES; s++) begin
        if (!hit_s[p] && id_rd_en[p] && valid_r[s] &&
            (addr_r[s] == id_rd_addr[p*ADDR_W +: ADDR_W])) begin
          hit_s[p] = 1'b1;
          if (stg_rdy[s]) begin
            fwd_en[p]                       = 1'b1;
            fwd_data[p*DATA_W +: DATA_W]    = stg_data[s*DATA_W +: DATA_W];
          end else begin
            port_stall_s[p] = 1'b1;
          end
        end else begin
          hit_s[p] = hit_s[p];
        end
      end
    end
  end

  // A not-ready youngest producer blocks decode unless the pipe is being flushed.
  assign stall = id_valid & ~flush & (|port_stall_s);

  // Advance the entries one stage per cycle; a stalled or idle decode inserts a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= '0;
      for (int s = 0; s < STAGES; s++) begin
        addr_r[s] <= '0;
      end
    end else if (flush) begin
      valid_r <= '0;
    end else begin
      valid_r[0] <= id_valid & id_wb_en & ~stall;
      addr_r[0]  <= id_wb_addr;
      for (int s = 1; s < STAGES; s++) begin
        valid_r[s] <= valid_r[s-1];
        addr_r[s]  <= addr_r[s-1];
      end
    end
  end

`ifdef FWD_STATS_EN
  logic [15:0] stall_cnt_r;
  logic [15:0] fwd_cnt_r;

  // Saturating counts of stall cycles and cycles with at least one forward.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 16'h0000;
      fwd_cnt_r   <= 16'h0000;
    end else begin
      if (stall && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if ((|fwd_en) && (fwd_cnt_r != 16'hFFFF)) begin
        fwd_cnt_r <= fwd_cnt_r + 16'd1;
      end else begin
        fwd_cnt_r <= fwd_cnt_r;
      end
    end
  end

  assign stat_stall_cnt = stall_cnt_r;
  assign stat_fwd_cnt   = fwd_cnt_r;
`else
  assign stat_stall_cnt = 16'h0000;
  assign stat_fwd_cnt   = 16'h0000;
`endif

endmodule
